// File: rtl/fifo_burst_reader.sv
// Drains a synchronous FIFO in fixed-length bursts: one (address, length) command,
// then the matching data beats on a valid/ready stream, with flush and frame wrap.
module fifo_burst_reader #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 10,
    parameter int          BURST_LEN   = 16,
    parameter int          RD_LATENCY  = 1,
    parameter int          SKID_DEPTH  = 4,
    parameter int          FRAME_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic                  clk_tb,
    input  logic                  tb_rst,
    input  logic                  fifo_wr_fire,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  flush,
    input  logic                  frame_start,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [31:0]           cmd_addr,
    output logic [ADDR_WIDTH:0]   cmd_len,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_last,
    output logic                  busy
);
    localparam int CW    = ADDR_WIDTH + 1;
    localparam int OFF_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int SK_AW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int SK_CW = $clog2(SKID_DEPTH + 1);
    localparam logic [CW-1:0] BURST = CW'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t                    state;
    logic [CW-1:0]             fill_cnt;
    logic [CW-1:0]             issued;
    logic [CW-1:0]             beat_cnt;
    logic [OFF_W-1:0]          offset;
    logic                      flush_pend;
    logic                      fs_pend;
    logic                      cmd_is_flush;
    logic [RD_LATENCY-1:0]     rd_pipe;
    logic [SK_CW-1:0]          inflight;
    logic [DATA_WIDTH-1:0]     skid_mem [SKID_DEPTH];
    logic [SK_AW-1:0]          skid_wp;
    logic [SK_AW-1:0]          skid_rp;
    logic [SK_CW-1:0]          skid_cnt;

    logic                      rd_cap;
    logic                      dout_beat;
    logic                      flush_clr;
    logic [OFF_W-1:0]          start_off;
    logic [31:0]               addr_next;
    logic [31:0]               off_sum;
    logic [OFF_W-1:0]          off_next;

    assign cmd_valid  = (state == CMD);
    assign busy       = (state != IDLE);
    assign dout_valid = (skid_cnt != '0);
    assign dout_data  = skid_mem[skid_rp];
    assign dout_last  = dout_valid && (beat_cnt + 1'b1 == cmd_len);
    assign dout_beat  = dout_valid && dout_ready;
    assign rd_cap     = rd_pipe[RD_LATENCY-1];

    // Reads are throttled so every word in flight already owns a skid slot.
    assign fifo_rd_en = (state == DATA) && !fifo_empty && (issued < cmd_len)
                        && ((32'(skid_cnt) + 32'(inflight)) < 32'(SKID_DEPTH));

    always_comb begin
        flush_clr = 1'b0;
        if (state == CMD && cmd_ready && cmd_is_flush) flush_clr = 1'b1;
        if (state == IDLE && fill_cnt == '0)           flush_clr = 1'b1;
    end

    // A frame_start seen now or held from a busy period rebases the next command.
    always_comb begin
        start_off = (frame_start || fs_pend) ? '0 : offset;
        addr_next = BASE_ADDR + 32'(start_off) * 32'(DATA_WIDTH / 8);
        off_sum   = 32'(offset) + 32'(cmd_len);
        off_next  = (off_sum >= 32'(FRAME_WORDS)) ? OFF_W'(off_sum - 32'(FRAME_WORDS))
                                                  : OFF_W'(off_sum);
    end

    // Read-latency pipeline and skid buffer.
    always_ff @(posedge clk_tb or posedge tb_rst) begin
        if (tb_rst) begin
            rd_pipe  <= '0;
            inflight <= '0;
            skid_wp  <= '0;
            skid_rp  <= '0;
            skid_cnt <= '0;
            // NOTE: the skid array is small and drives dout_data directly, so it is
            // reset to keep the data output at 0 after reset; a large RAM would not be.
            for (int i = 0; i < SKID_DEPTH; i++) skid_mem[i] <= '0;
        end else begin
            rd_pipe  <= (rd_pipe << 1) | RD_LATENCY'(fifo_rd_en);
            inflight <= inflight + SK_CW'(fifo_rd_en) - SK_CW'(rd_cap);
            if (rd_cap) begin
                skid_mem[skid_wp] <= fifo_rd_data;
                skid_wp <= (skid_wp == SK_AW'(SKID_DEPTH - 1)) ? '0 : skid_wp + 1'b1;
            end
            if (dout_beat)
                skid_rp <= (skid_rp == SK_AW'(SKID_DEPTH - 1)) ? '0 : skid_rp + 1'b1;
            skid_cnt <= skid_cnt + SK_CW'(rd_cap) - SK_CW'(dout_beat);
        end
    end

    always_ff @(posedge clk_tb or posedge tb_rst) begin
        if (tb_rst) begin
            state        <= IDLE;
            fill_cnt     <= '0;
            issued       <= '0;
            beat_cnt     <= '0;
            offset       <= '0;
            flush_pend   <= 1'b0;
            fs_pend      <= 1'b0;
            cmd_is_flush <= 1'b0;
            cmd_addr     <= '0;
            cmd_len      <= '0;
        end else begin
            case ({fifo_wr_fire, fifo_rd_en})
                2'b10:   fill_cnt <= fill_cnt + 1'b1;
                2'b01:   fill_cnt <= fill_cnt - 1'b1;
                default: ;
            endcase

            // A new flush request wins over a same-cycle clear.
            if (flush)          flush_pend <= 1'b1;
            else if (flush_clr) flush_pend <= 1'b0;

            case (state)
                IDLE: begin
                    if (frame_start || fs_pend) begin
                        offset  <= '0;
                        fs_pend <= 1'b0;
                    end
                    if (fill_cnt >= BURST) begin
                        state        <= CMD;
                        cmd_len      <= BURST;
                        cmd_addr     <= addr_next;
                        cmd_is_flush <= 1'b0;
                    end else if (flush_pend && fill_cnt != '0) begin
                        state        <= CMD;
                        cmd_len      <= fill_cnt;
                        cmd_addr     <= addr_next;
                        cmd_is_flush <= 1'b1;
                    end
                end
                CMD: begin
                    if (frame_start) fs_pend <= 1'b1;
                    if (cmd_ready) begin
                        offset   <= off_next;
                        issued   <= '0;
                        beat_cnt <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (frame_start) fs_pend <= 1'b1;
                    if (fifo_rd_en) issued <= issued + 1'b1;
                    if (dout_beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (dout_last) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader driving a behavioural source FIFO; the frame
// is 48 words so wrap-around is reached within a few bursts.
module tb_fifo_burst_reader;
    logic        clk_tb, tb_rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        fifo_wr_fire, fifo_empty, fifo_rd_en;
    logic [31:0] fifo_rd_data;
    logic        flush, frame_start;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [10:0] cmd_len;
    logic        dout_valid, dout_ready, dout_last, busy;
    logic [31:0] dout_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    fifo_burst_reader #(.FRAME_WORDS(48)) dut (
        .clk_tb(clk_tb), .tb_rst(tb_rst),
        .fifo_wr_fire(fifo_wr_fire), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .flush(flush), .frame_start(frame_start),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_data(dout_data), .dout_last(dout_last), .busy(busy)
    );

    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;
    always @(posedge clk_tb) cyc <= cyc + 1;

    // Source FIFO: depth 1024, rd_data valid one cycle after rd_en.
    logic [31:0] fmem [1024];
    logic [9:0]  fwp, frp;
    logic [10:0] fcnt;
    assign fifo_empty   = (fcnt == 11'd0);
    assign fifo_wr_fire = wr_en && (fcnt != 11'd1024);

    always @(posedge clk_tb or posedge tb_rst) begin
        if (tb_rst) begin
            fwp <= '0; frp <= '0; fcnt <= '0; fifo_rd_data <= '0;
        end else begin
            if (fifo_wr_fire) begin
                fmem[fwp] <= wr_data;
                fwp <= fwp + 1'b1;
            end
            if (fifo_rd_en) begin
                fifo_rd_data <= fmem[frp];
                frp <= frp + 1'b1;
            end
            fcnt <= fcnt + 11'(fifo_wr_fire) - 11'(fifo_rd_en);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transfers are recorded at the falling edge, before the rising edge that takes them.
    logic [31:0] cmd_addr_q[$];
    logic [10:0] cmd_len_q[$];
    int          cmd_cyc_q[$];
    logic [31:0] beat_data_q[$];
    logic        beat_last_q[$];
    int          beat_cyc_q[$];
    logic        p_cv, p_cr, p_dv, p_dr, p_last;
    logic [31:0] p_addr, p_data;
    logic [10:0] p_len;

    always @(negedge clk_tb) begin
        if (!tb_rst) begin
            if (p_cv && !p_cr) begin
                check("cmd_hold_valid", cmd_valid, 1'b1);
                check("cmd_hold_addr", cmd_addr, p_addr);
                check("cmd_hold_len", cmd_len, p_len);
            end
            if (p_dv && !p_dr) begin
                check("dout_hold_valid", dout_valid, 1'b1);
                check("dout_hold_data", dout_data, p_data);
                check("dout_hold_last", dout_last, p_last);
            end
            if (cmd_valid) check("rd_before_cmd", fifo_rd_en, 1'b0);
            if (fifo_rd_en) check("rd_when_empty", fifo_empty, 1'b0);
            if (busy) check("skid_bound", (32'(dut.skid_cnt) + 32'(dut.inflight)) <= 32'd4, 1'b1);
            if (cmd_valid && cmd_ready) begin
                cmd_addr_q.push_back(cmd_addr);
                cmd_len_q.push_back(cmd_len);
                cmd_cyc_q.push_back(cyc);
            end
            if (dout_valid && dout_ready) begin
                beat_data_q.push_back(dout_data);
                beat_last_q.push_back(dout_last);
                beat_cyc_q.push_back(cyc);
            end
        end
        p_cv = cmd_valid;  p_cr = cmd_ready;  p_addr = cmd_addr;  p_len = cmd_len;
        p_dv = dout_valid; p_dr = dout_ready; p_data = dout_data; p_last = dout_last;
    end

    task automatic tick();
        @(posedge clk_tb);
        #1;
    endtask

    task automatic clear_q();
        cmd_addr_q.delete(); cmd_len_q.delete(); cmd_cyc_q.delete();
        beat_data_q.delete(); beat_last_q.delete(); beat_cyc_q.delete();
    endtask

    task automatic write_words(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = first + 32'(i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    // Returns just after the rising edge that takes the n-th recorded beat.
    task automatic wait_beats(input string tag, input int n);
        int k = 0;
        while (beat_data_q.size() < n && k < 300) begin
            @(posedge clk_tb);
            #2;
            k++;
        end
        check({tag, "_done"}, beat_data_q.size() >= n, 1'b1);
    endtask

    task automatic check_stream(input string tag, input logic [31:0] first, input int n,
                                input int blen, input bit tail_last);
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, beat_data_q[i], first + 32'(i));
            check({tag, "_last"}, beat_last_q[i],
                  ((i + 1) % blen == 0) || (tail_last && i == n - 1));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_valid"}, cmd_valid, 1'b0);
        check({tag, "_cmd_addr"}, cmd_addr, 32'h0);
        check({tag, "_cmd_len"}, cmd_len, 11'h0);
        check({tag, "_dout_valid"}, dout_valid, 1'b0);
        check({tag, "_dout_data"}, dout_data, 32'h0);
        check({tag, "_dout_last"}, dout_last, 1'b0);
        check({tag, "_rd_en"}, fifo_rd_en, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic pat [4];
        int   k;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        tb_rst = 1'b1; wr_en = 1'b0; wr_data = '0; flush = 1'b0;
        frame_start = 1'b0; cmd_ready = 1'b1; dout_ready = 1'b1;
        repeat (2) @(posedge clk_tb);
        #1;
        check_idle_outputs("reset");
        tb_rst = 1'b0;
        tick();

        // Single full burst: address 0, back-to-back beats, latency from accept.
        clear_q();
        write_words(32'd1, 16);
        wait_beats("t1", 16);
        check("t1_busy_fall", busy, 1'b0);
        check("t1_ncmd", cmd_addr_q.size(), 1);
        check("t1_addr", cmd_addr_q[0], 32'h0);
        check("t1_len", cmd_len_q[0], 11'd16);
        check("t1_first_lat", beat_cyc_q[0], cmd_cyc_q[0] + 3);
        check("t1_rate", beat_cyc_q[15], beat_cyc_q[0] + 15);
        check_stream("t1", 32'd1, 16, 16, 1'b1);

        // Two full bursts then a flushed partial; offsets 0, 16, 32.
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        clear_q();
        write_words(32'd101, 40);
        flush = 1'b1; tick(); flush = 1'b0;
        wait_beats("t2", 40);
        check("t2_ncmd", cmd_addr_q.size(), 3);
        check("t2_addr0", cmd_addr_q[0], 32'h0);
        check("t2_addr1", cmd_addr_q[1], 32'h40);
        check("t2_addr2", cmd_addr_q[2], 32'h80);
        check("t2_len0", cmd_len_q[0], 11'd16);
        check("t2_len1", cmd_len_q[1], 11'd16);
        check("t2_len2", cmd_len_q[2], 11'd8);
        check_stream("t2", 32'd101, 40, 16, 1'b1);

        // Flush request consumed: 10 words sit until a new flush; offset 40 -> wraps to 2.
        clear_q();
        write_words(32'd141, 10);
        repeat (40) tick();
        check("t2b_no_cmd", cmd_addr_q.size(), 0);
        flush = 1'b1; tick(); flush = 1'b0;
        wait_beats("t2b", 10);
        check("t2b_addr", cmd_addr_q[0], 32'hA0);
        check("t2b_len", cmd_len_q[0], 11'd10);
        check_stream("t2b", 32'd141, 10, 16, 1'b1);

        // Command stall then a throttled output; address reflects the wrapped offset 2.
        clear_q();
        cmd_ready = 1'b0;
        write_words(32'd201, 16);
        k = 0;
        while (!cmd_valid && k < 100) begin tick(); k++; end
        check("t3_cmd_seen", cmd_valid, 1'b1);
        repeat (5) tick();
        check("t3_no_accept", cmd_addr_q.size(), 0);
        check("t3_addr", cmd_addr, 32'h8);
        check("t3_len", cmd_len, 11'd16);
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
        k = 0;
        while (beat_data_q.size() < 16 && k < 300) begin
            dout_ready = pat[k % 4];
            tick();
            k++;
        end
        dout_ready = 1'b1;
        cmd_ready  = 1'b1;
        repeat (5) tick();
        check("t3_nbeats", beat_data_q.size(), 16);
        check_stream("t3", 32'd201, 16, 16, 1'b1);

        // frame_start during a burst only takes effect for the following command.
        clear_q();
        write_words(32'd301, 16);
        wait_beats("t4a", 1);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        wait_beats("t4b", 16);
        write_words(32'd317, 16);
        wait_beats("t4c", 32);
        check("t4_ncmd", cmd_addr_q.size(), 2);
        check("t4_addr0", cmd_addr_q[0], 32'h48);
        check("t4_addr1", cmd_addr_q[1], 32'h0);
        check_stream("t4", 32'd301, 32, 16, 1'b1);

        // Reset after beat 7 abandons the burst; a fresh burst restarts at address 0.
        clear_q();
        write_words(32'd401, 16);
        wait_beats("t5a", 7);
        tb_rst = 1'b1;
        #1;
        check_idle_outputs("t5_rst");
        check("t5_addr_pre", cmd_addr_q[0], 32'h40);
        check("t5_nbeats_pre", beat_data_q.size(), 7);
        check_stream("t5_pre", 32'd401, 7, 16, 1'b0);
        repeat (3) tick();
        tb_rst = 1'b0;
        clear_q();
        repeat (20) tick();
        check("t5_idle_no_cmd", cmd_addr_q.size(), 0);
        check("t5_idle_busy", busy, 1'b0);
        write_words(32'd501, 16);
        wait_beats("t5b", 16);
        check("t5_addr", cmd_addr_q[0], 32'h0);
        check("t5_len", cmd_len_q[0], 11'd16);
        check_stream("t5", 32'd501, 16, 16, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
